image_row_buffer: RTL and testbench

- Line-buffer stage directly upstream of the 3x3 window generator in the image path.
- Accepts a raster stream of already-padded pixels, one per cycle, and stores them in four rotating row banks.
- When three consecutive rows are resident, pulses Row_Compute_Sign and serves the three rows column-aligned on a 3-pixel bus addressed by the downstream Addr.
- Image is square: N = Row_Num_After_Padding rows by N columns.

---
 rtl/image_row_buffer_if.sv | 27 ++
 rtl/image_row_buffer.sv | 157 +++++++++++++++
 tb/tb_image_row_buffer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_row_buffer_if.sv
// Pixel-stream and window-read bundle between the padding stage, the row buffer
// and the 3x3 window generator.
interface image_row_buffer_if #(
    parameter int IMAGE_WIDTH_DATA = 8,
    parameter int ADDR_W           = 10
);
    logic                            Start;
    logic [ADDR_W-1:0]               Row_Num_After_Padding;
    logic [IMAGE_WIDTH_DATA-1:0]     S_Data;
    logic                            S_Valid;
    logic                            S_Ready;
    logic [ADDR_W-1:0]               Addr;
    logic [3*IMAGE_WIDTH_DATA-1:0]   M_Feature;
    logic                            Row_Compute_Sign;
    logic                            Row_Done;
    logic                            Done;

    modport master (
        output Start, Row_Num_After_Padding, S_Data, S_Valid, Addr, Row_Done,
        input  S_Ready, M_Feature, Row_Compute_Sign, Done
    );

    modport slave (
        input  Start, Row_Num_After_Padding, S_Data, S_Valid, Addr, Row_Done,
        output S_Ready, M_Feature, Row_Compute_Sign, Done
    );
endinterface

// File: rtl/image_row_buffer.sv
// Four-bank rotating line buffer: stores a padded raster stream and serves three
// consecutive rows column-aligned to the 3x3 window generator.
module image_row_buffer #(
    parameter int IMAGE_WIDTH_DATA = 8,
    parameter int BANK_DEPTH       = 1024,
    parameter int ADDR_W           = 10
) (
    input  logic              clk,
    input  logic              rst,
    image_row_buffer_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_W:0]   EXT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   EXT_THREE = {{(ADDR_W-1){1'b0}}, 2'b11};
    localparam logic [ADDR_W:0]   EXT_FOUR  = {{(ADDR_W-2){1'b0}}, 3'b100};
    localparam logic [ADDR_W-1:0] COL_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]                      state_r, state_nxt_s;
    logic [ADDR_W:0]                 n_r, n_nxt_s, n_start_s;
    logic [ADDR_W-1:0]               wr_col_r, col_nxt_s;
    logic [ADDR_W:0]                 wr_row_r, row_nxt_s;
    logic [ADDR_W-1:0]               win_r, win_nxt_s;
    logic                            active_r, active_nxt_s;
    logic                            ready_r, ready_nxt_s;
    logic                            sign_r;
    logic                            done_r;
    logic [3*IMAGE_WIDTH_DATA-1:0]   feat_r;

    logic                            accept_s;
    logic                            last_col_s;
    logic                            last_win_s;
    logic                            row_done_s;
    logic                            issue_s;
    logic [ADDR_W:0]                 rows_filled_s;
    logic [1:0]                      bank_top_s, bank_mid_s, bank_bot_s;

    logic [IMAGE_WIDTH_DATA-1:0]     bank_mem [0:3][0:BANK_DEPTH-1];

    // A code of zero on the 10-bit size port stands for the full 1024-wide frame.
    assign n_start_s     = (bus.Row_Num_After_Padding == {ADDR_W{1'b0}}) ?
                           {1'b1, {ADDR_W{1'b0}}} : {1'b0, bus.Row_Num_After_Padding};
    assign accept_s      = bus.S_Valid && ready_r;
    assign last_col_s    = ({1'b0, wr_col_r} == (n_r - EXT_ONE));
    assign last_win_s    = ({1'b0, win_r} == (n_r - EXT_THREE));
    assign row_done_s    = bus.Row_Done && active_r;
    assign rows_filled_s = (accept_s && last_col_s) ? (wr_row_r + EXT_ONE) : wr_row_r;
    // Look ahead at the row count so the pulse lands the cycle right after the row closes.
    assign issue_s       = (state_r == ST_RUN) && !active_r && !bus.Row_Done &&
                           (rows_filled_s >= ({1'b0, win_r} + EXT_THREE));

    assign bank_top_s = win_r[1:0];
    assign bank_mid_s = win_r[1:0] + 2'd1;
    assign bank_bot_s = win_r[1:0] + 2'd2;

    // Next-state logic for frame control, write counters and window tracking.
    always_comb begin
        state_nxt_s  = state_r;
        n_nxt_s      = n_r;
        col_nxt_s    = wr_col_r;
        row_nxt_s    = wr_row_r;
        win_nxt_s    = win_r;
        active_nxt_s = active_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.Start) begin
                    n_nxt_s      = n_start_s;
                    col_nxt_s    = {ADDR_W{1'b0}};
                    row_nxt_s    = {(ADDR_W+1){1'b0}};
                    win_nxt_s    = {ADDR_W{1'b0}};
                    active_nxt_s = 1'b0;
                    state_nxt_s  = ST_RUN;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                row_nxt_s = rows_filled_s;
                if (accept_s) begin
                    col_nxt_s = last_col_s ? {ADDR_W{1'b0}} : (wr_col_r + COL_ONE);
                end else begin
                    col_nxt_s = wr_col_r;
                end
                if (row_done_s) begin
                    active_nxt_s = 1'b0;
                    win_nxt_s    = win_r + COL_ONE;
                    state_nxt_s  = last_win_s ? ST_DONE : ST_RUN;
                end else if (issue_s) begin
                    active_nxt_s = 1'b1;
                end else begin
                    active_nxt_s = active_r;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // The fourth bank is the only free one while window win is being read.
        ready_nxt_s = (state_nxt_s == ST_RUN) && (row_nxt_s < n_nxt_s) &&
                      (row_nxt_s < ({1'b0, win_nxt_s} + EXT_FOUR));
    end

    // Control registers and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            n_r      <= {(ADDR_W+1){1'b0}};
            wr_col_r <= {ADDR_W{1'b0}};
            wr_row_r <= {(ADDR_W+1){1'b0}};
            win_r    <= {ADDR_W{1'b0}};
            active_r <= 1'b0;
            ready_r  <= 1'b0;
            sign_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            n_r      <= n_nxt_s;
            wr_col_r <= col_nxt_s;
            wr_row_r <= row_nxt_s;
            win_r    <= win_nxt_s;
            active_r <= active_nxt_s;
            ready_r  <= ready_nxt_s;
            sign_r   <= issue_s;
            done_r   <= (state_nxt_s == ST_DONE);
        end
    end

    // Row bank write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept_s && !rst) begin
            bank_mem[wr_row_r[1:0]][wr_col_r] <= bus.S_Data;
        end
    end

    // Column read of the three window rows, one cycle after Addr.
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_r <= {(3*IMAGE_WIDTH_DATA){1'b0}};
        end else begin
            feat_r <= {bank_mem[bank_bot_s][bus.Addr],
                       bank_mem[bank_mid_s][bus.Addr],
                       bank_mem[bank_top_s][bus.Addr]};
        end
    end

    assign bus.S_Ready          = ready_r;
    assign bus.Row_Compute_Sign = sign_r;
    assign bus.Done             = done_r;
    assign bus.M_Feature        = feat_r;

endmodule

// File: tb/tb_image_row_buffer.sv
// Directed bench for image_row_buffer: a pixel-count based frame model checked
// every cycle, plus literal expectations for counts, timing and window data.
module tb_image_row_buffer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    image_row_buffer_if #(.IMAGE_WIDTH_DATA(8), .ADDR_W(10)) bus ();

    image_row_buffer #(.IMAGE_WIDTH_DATA(8), .BANK_DEPTH(1024), .ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  n_cmp = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    // frame model state: everything derived from the count of accepted pixels
    int          m_n = 1, m_cnt = 0, m_win = 0, m_pulses = 0;
    bit          m_run = 1'b0, m_done_st = 1'b0, m_active = 1'b0;
    bit          exp_ready = 1'b0, exp_sign = 1'b0, exp_done = 1'b0, feat_known = 1'b1;
    logic [23:0] exp_feat = 24'h0;
    logic [7:0]  img [0:4095];

    bit  lit_en = 1'b0, lit_w2 = 1'b0;
    int  lit_addr = 0;

    int  rd_delay = 0, cd = 0, addr_ctr = 0;
    bit  rnd_valid = 1'b0, rd_force = 1'b0;
    int  dut_pulses = 0, dut_dones = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc, pulse_ok, next_done;
        int a;
        a = int'(bus.Addr);
        if (rst) begin
            m_run = 1'b0; m_done_st = 1'b0; m_active = 1'b0;
            m_cnt = 0; m_win = 0; m_n = 1;
            exp_ready = 1'b0; exp_sign = 1'b0; exp_done = 1'b0;
            exp_feat = 24'h0; feat_known = 1'b1; lit_w2 = 1'b0;
            return;
        end
        lit_w2   = lit_en && m_active && (m_win == 2) && (a < m_n);
        lit_addr = a;
        if (m_active && (a < m_n)) begin
            exp_feat   = {img[(m_win+2)*m_n + a], img[(m_win+1)*m_n + a], img[m_win*m_n + a]};
            feat_known = 1'b1;
        end else begin
            feat_known = 1'b0;
        end
        acc       = exp_ready && bus.S_Valid;
        pulse_ok  = 1'b0;
        next_done = 1'b0;
        if (!m_run && !m_done_st) begin
            if (bus.Start) begin
                m_n      = (bus.Row_Num_After_Padding == 10'd0) ? 1024 : int'(bus.Row_Num_After_Padding);
                m_cnt    = 0;
                m_win    = 0;
                m_active = 1'b0;
                m_pulses = 0;
                m_run    = 1'b1;
            end
        end else if (m_run) begin
            if (acc) begin
                img[m_cnt] = bus.S_Data;
                m_cnt++;
            end
            if (bus.Row_Done && m_active) begin
                m_active = 1'b0;
                if (m_win == m_n - 3) begin
                    m_run     = 1'b0;
                    next_done = 1'b1;
                end
                m_win++;
            end else begin
                pulse_ok = !m_active && !bus.Row_Done && ((m_cnt / m_n) >= m_win + 3);
            end
        end
        if (pulse_ok) begin
            m_active = 1'b1;
            m_pulses++;
        end
        m_done_st = next_done;
        exp_done  = next_done;
        exp_sign  = pulse_ok;
        exp_ready = m_run && (m_cnt < m_n * m_n) && ((m_cnt / m_n) < m_win + 4);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // compare process: every output every cycle, feature data only where defined
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("s_ready", 24'(bus.S_Ready), 24'(exp_ready));
                check("row_compute_sign", 24'(bus.Row_Compute_Sign), 24'(exp_sign));
                check("done", 24'(bus.Done), 24'(exp_done));
                if (feat_known) check("m_feature", bus.M_Feature, exp_feat);
                if (lit_w2) begin
                    logic [7:0] c8;
                    c8 = 8'(lit_addr);
                    check("win2_literal", bus.M_Feature, {8'h40 + c8, 8'h30 + c8, 8'h20 + c8});
                end
                dut_pulses += int'(bus.Row_Compute_Sign);
                dut_dones  += int'(bus.Done);
            end
        end
    end

    task automatic drive_inputs();
        int n_eff;
        n_eff = (m_n > 0) ? m_n : 1;
        bus.Row_Done = 1'b0;
        if (rd_force) begin
            bus.Row_Done = 1'b1;
            rd_force = 1'b0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) bus.Row_Done = 1'b1;
        end
        if (exp_sign && rd_delay > 0) cd = rd_delay;
        bus.S_Valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.S_Data  = 8'(((m_cnt / n_eff) * 16) + (m_cnt % n_eff));
        bus.Addr    = 10'(addr_ctr % n_eff);
        addr_ctr++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic start_frame(input int n);
        dut_pulses = 0;
        dut_dones  = 0;
        bus.Row_Num_After_Padding = 10'(n);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
    endtask

    task automatic wait_cnt(input int target, input int budget);
        int k;
        k = 0;
        while (m_cnt < target && k < budget) begin
            step();
            k++;
        end
        check("pixels_reached", 24'(m_cnt), 24'(target));
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!exp_done && k < budget) begin
            step();
            k++;
        end
        check("frame_done_reached", 24'(exp_done), 24'd1);
        repeat (3) step();
    endtask

    initial begin
        rst = 1'b1;
        bus.Start = 1'b0;
        bus.Row_Num_After_Padding = 10'd0;
        bus.S_Valid = 1'b0;
        bus.S_Data = 8'h00;
        bus.Addr = 10'd0;
        bus.Row_Done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_s_ready", 24'(bus.S_Ready), 24'd0);
        check("reset_m_feature", bus.M_Feature, 24'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // N=6, continuous input, Row_Done 8 cycles after each pulse
        rd_delay = 8; rnd_valid = 1'b0; lit_en = 1'b1; addr_ctr = 0;
        start_frame(6);
        wait_cnt(18, 200);
        @(negedge clk);
        check("first_pulse_after_px18", 24'(bus.Row_Compute_Sign), 24'd1);
        wait_done(500);
        lit_en = 1'b0;
        check("n6_pixels", 24'(m_cnt), 24'd36);
        check("n6_model_pulses", 24'(m_pulses), 24'd4);
        check("n6_dut_pulses", 24'(dut_pulses), 24'd4);
        check("n6_dut_done", 24'(dut_dones), 24'd1);

        // N=8, Row_Done withheld after the first pulse
        rd_delay = 0;
        start_frame(8);
        wait_cnt(32, 300);
        repeat (20) step();
        @(negedge clk);
        check("stall_pixels", 24'(m_cnt), 24'd32);
        check("stall_ready_low", 24'(bus.S_Ready), 24'd0);
        check("stall_one_pulse", 24'(dut_pulses), 24'd1);
        rd_force = 1'b1;
        rd_delay = 3;
        step();
        step();
        @(negedge clk);
        check("ready_restored", 24'(bus.S_Ready), 24'd1);
        wait_done(1000);
        check("n8_pixels", 24'(m_cnt), 24'd64);
        check("n8_dut_pulses", 24'(dut_pulses), 24'd6);
        check("n8_dut_done", 24'(dut_dones), 24'd1);

        // N=5, random S_Valid, stray Start and size change mid-frame
        rnd_valid = 1'b1; rd_delay = 4;
        start_frame(5);
        wait_cnt(10, 300);
        bus.Start = 1'b1;
        bus.Row_Num_After_Padding = 10'd3;
        step();
        bus.Start = 1'b0;
        wait_done(2000);
        check("n5_pixels", 24'(m_cnt), 24'd25);
        check("n5_dut_pulses", 24'(dut_pulses), 24'd3);
        check("n5_dut_done", 24'(dut_dones), 24'd1);

        // reset in the middle of row 4 of an N=8 frame, then an N=3 frame
        rnd_valid = 1'b0; rd_delay = 2;
        start_frame(8);
        wait_cnt(35, 300);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cd = 0;
        @(negedge clk);
        check("post_reset_s_ready", 24'(bus.S_Ready), 24'd0);
        check("post_reset_sign", 24'(bus.Row_Compute_Sign), 24'd0);
        check("post_reset_done", 24'(bus.Done), 24'd0);
        check("post_reset_feature", bus.M_Feature, 24'h0);
        start_frame(3);
        wait_done(200);
        check("n3_pixels", 24'(m_cnt), 24'd9);
        check("n3_dut_pulses", 24'(dut_pulses), 24'd1);
        check("n3_dut_done", 24'(dut_dones), 24'd1);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
